// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU sequencer: instruction opcodes, ALU opcodes,
// sequencer states and the opcode-to-ALU-operation mapping.
package cpu_pkg;

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_JMP = 3'b001;
   localparam logic [2:0] OP_INC = 3'b010;
   localparam logic [2:0] OP_DEC = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_SKZ = 3'b111;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_INC  = 2'b01;
   localparam logic [1:0] ALU_DEC  = 2'b10;
   localparam logic [1:0] ALU_ADD  = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_INSTR,
      ST_OPRD,
      ST_OPND,
      ST_EXEC,
      ST_WB,
      ST_JUMP,
      ST_STORE,
      ST_SKIP,
      ST_HALT
   } state_t;

   function automatic logic [1:0] alu_op_for(input logic [2:0] i_opc);
      logic [1:0] w_op;
      w_op = ALU_PASS;
      case (i_opc)
         OP_INC:  w_op = ALU_INC;
         OP_DEC:  w_op = ALU_DEC;
         OP_ADD:  w_op = ALU_ADD;
         default: w_op = ALU_PASS;
      endcase
      return w_op;
   endfunction

endpackage

// File: rtl/cpu_pc.sv
// Program counter: load has priority over increment; wraps modulo 2^ADDR_W.
// o_pc_next exposes the value the PC takes at the coming edge.
module cpu_pc #(
   parameter int unsigned           ADDR_W = 5,
   parameter logic [ADDR_W-1:0]     RST_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_val,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_pc,
   output logic [ADDR_W-1:0] o_pc_next
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;

   always_comb begin
      w_pc_next = r_pc;
      if (i_load) begin
         w_pc_next = i_load_val;
      end else if (i_inc) begin
         w_pc_next = r_pc + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RST_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   assign o_pc      = r_pc;
   assign o_pc_next = w_pc_next;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/control stage in front of the 8-bit ALU. Owns IR and accumulator;
// every memory/ALU control output is registered and set on entry to its state.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W = 5,
   parameter logic [ADDR_W-1:0] RST_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              alu_clk,
   output logic [1:0]        alu_op,
   output logic [7:0]        alu_data,
   output logic [7:0]        accum,
   input  logic [7:0]        alu_out,
   input  logic              zero,
   output logic              halted
);

   state_t            r_state;
   logic [7:0]        r_ir;
   logic [7:0]        r_accum;
   logic [7:0]        r_alu_data;
   logic [1:0]        r_alu_op;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic              r_alu_clk;
   logic              r_halted;

   logic [ADDR_W-1:0] w_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_pc_load;
   logic              w_pc_inc;
   logic [2:0]        w_rd_opc;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [ADDR_W-1:0] w_ir_addr;

   assign w_rd_opc  = mem_rdata[7:5];
   assign w_rd_addr = mem_rdata[ADDR_W-1:0];
   assign w_ir_addr = r_ir[ADDR_W-1:0];

   always_comb begin
      w_pc_load = 1'b0;
      w_pc_inc  = 1'b0;
      case (r_state)
         ST_INSTR: w_pc_inc  = 1'b1;
         ST_JUMP:  w_pc_load = 1'b1;
         ST_SKIP:  w_pc_inc  = zero;
         default: begin
            w_pc_load = 1'b0;
            w_pc_inc  = 1'b0;
         end
      endcase
   end

   cpu_pc #(
      .ADDR_W (ADDR_W),
      .RST_PC (RST_PC)
   ) u_pc (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_pc_load),
      .i_load_val (w_ir_addr),
      .i_inc      (w_pc_inc),
      .o_pc       (w_pc),
      .o_pc_next  (w_pc_next)
   );

   // Entering FETCH uses the PC's next value so a JUMP/SKIP update lands in the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ir       <= '0;
         r_accum    <= '0;
         r_alu_data <= '0;
         r_alu_op   <= ALU_PASS;
         r_mem_addr <= RST_PC;
         r_mem_rd   <= 1'b0;
         r_mem_wr   <= 1'b0;
         r_alu_clk  <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_mem_rd  <= 1'b0;
         r_mem_wr  <= 1'b0;
         r_alu_clk <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state    <= ST_FETCH;
                  r_mem_addr <= w_pc_next;
                  r_mem_rd   <= 1'b1;
               end
            end
            ST_FETCH: begin
               r_state <= ST_INSTR;
            end
            ST_INSTR: begin
               r_ir     <= mem_rdata;
               r_alu_op <= alu_op_for(w_rd_opc);
               case (w_rd_opc)
                  OP_HLT: begin
                     r_state  <= ST_HALT;
                     r_halted <= 1'b1;
                  end
                  OP_JMP: r_state <= ST_JUMP;
                  OP_INC, OP_DEC: begin
                     r_state   <= ST_EXEC;
                     r_alu_clk <= 1'b1;
                  end
                  OP_ADD, OP_LDA: begin
                     r_state    <= ST_OPRD;
                     r_mem_addr <= w_rd_addr;
                     r_mem_rd   <= 1'b1;
                  end
                  OP_STO: begin
                     r_state    <= ST_STORE;
                     r_mem_addr <= w_rd_addr;
                     r_mem_wr   <= 1'b1;
                  end
                  default: r_state <= ST_SKIP;
               endcase
            end
            ST_OPRD: begin
               r_state <= ST_OPND;
            end
            ST_OPND: begin
               r_alu_data <= mem_rdata;
               if (r_ir[7:5] == OP_LDA) begin
                  r_accum    <= mem_rdata;
                  r_state    <= ST_FETCH;
                  r_mem_addr <= w_pc_next;
                  r_mem_rd   <= 1'b1;
               end else begin
                  r_state   <= ST_EXEC;
                  r_alu_clk <= 1'b1;
               end
            end
            ST_EXEC: begin
               r_state <= ST_WB;
            end
            ST_WB: begin
               r_accum    <= alu_out;
               r_state    <= ST_FETCH;
               r_mem_addr <= w_pc_next;
               r_mem_rd   <= 1'b1;
            end
            ST_JUMP, ST_STORE, ST_SKIP: begin
               r_state    <= ST_FETCH;
               r_mem_addr <= w_pc_next;
               r_mem_rd   <= 1'b1;
            end
            ST_HALT: begin
               if (start) begin
                  r_halted   <= 1'b0;
                  r_state    <= ST_FETCH;
                  r_mem_addr <= w_pc_next;
                  r_mem_rd   <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign mem_wdata = r_accum;
   assign alu_clk   = r_alu_clk;
   assign alu_op    = r_alu_op;
   assign alu_data  = r_alu_data;
   assign accum     = r_accum;
   assign halted    = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: byte memory and ALU environment, an instruction-level
// reference model producing per-cycle bus expectations, and directed programs.
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [4:0] mem_addr;
   logic       mem_rd;
   logic       mem_wr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       alu_clk;
   logic [1:0] alu_op;
   logic [7:0] alu_data;
   logic [7:0] accum;
   logic [7:0] alu_out;
   logic       zero;
   logic       halted;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_sequencer #(
      .ADDR_W (5),
      .RST_PC (5'd0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .alu_clk   (alu_clk),
      .alu_op    (alu_op),
      .alu_data  (alu_data),
      .accum     (accum),
      .alu_out   (alu_out),
      .zero      (zero),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   // Environment: synchronous byte memory with a bench back-door write port, and the ALU.
   logic [7:0] tb_mem [32];
   logic       tb_we = 1'b0;
   logic [4:0] tb_wa = '0;
   logic [7:0] tb_wd = '0;
   int         n_aclk = 0;

   always @(posedge clk) begin
      if (tb_we) tb_mem[tb_wa] <= tb_wd;
      else if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= tb_mem[mem_addr];
   end

   always @(posedge clk) begin
      if (alu_clk) begin
         n_aclk <= n_aclk + 1;
         case (alu_op)
            2'b00: alu_out <= alu_data;
            2'b01: alu_out <= accum + 8'd1;
            2'b10: alu_out <= accum - 8'd1;
            default: alu_out <= accum + alu_data;
         endcase
      end
   end

   assign zero = (accum == 8'h00);

   // Reference model: architectural state plus expected per-cycle bus activity.
   typedef struct packed {
      logic       rd;
      logic       wr;
      logic       aclk;
      logic       opv;
      logic [4:0] addr;
      logic [1:0] op;
   } cyc_t;

   cyc_t       exp_q [$];
   logic [7:0] m_mem [32];
   logic [4:0] m_pc;
   logic [7:0] m_acc;
   logic       m_ok;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input logic rd, input logic wr, input logic aclk, input logic opv,
                       input logic [4:0] a, input logic [1:0] op);
      cyc_t c;
      c.rd = rd; c.wr = wr; c.aclk = aclk; c.opv = opv; c.addr = a; c.op = op;
      exp_q.push_back(c);
   endtask

   task automatic model_run();
      logic [7:0] ins;
      logic [4:0] a;
      m_ok = 1'b0;
      for (int n = 0; n < 64; n++) begin
         ins = m_mem[m_pc];
         a   = ins[4:0];
         push(1, 0, 0, 0, m_pc, 2'b00);
         push(0, 0, 0, 0, 5'd0, 2'b00);
         m_pc = m_pc + 5'd1;
         case (ins[7:5])
            3'd0: begin m_ok = 1'b1; return; end
            3'd1: begin push(0, 0, 0, 0, 5'd0, 2'b00); m_pc = a; end
            3'd2: begin
               push(0, 0, 1, 1, 5'd0, 2'b01); push(0, 0, 0, 1, 5'd0, 2'b01);
               m_acc = m_acc + 8'd1;
            end
            3'd3: begin
               push(0, 0, 1, 1, 5'd0, 2'b10); push(0, 0, 0, 1, 5'd0, 2'b10);
               m_acc = m_acc - 8'd1;
            end
            3'd4: begin
               push(1, 0, 0, 0, a, 2'b00); push(0, 0, 0, 0, 5'd0, 2'b00);
               push(0, 0, 1, 1, 5'd0, 2'b11); push(0, 0, 0, 1, 5'd0, 2'b11);
               m_acc = m_acc + m_mem[a];
            end
            3'd5: begin
               push(1, 0, 0, 0, a, 2'b00); push(0, 0, 0, 0, 5'd0, 2'b00);
               m_acc = m_mem[a];
            end
            3'd6: begin push(0, 1, 0, 0, a, 2'b00); m_mem[a] = m_acc; end
            default: begin
               push(0, 0, 0, 0, 5'd0, 2'b00);
               if (m_acc == 8'h00) m_pc = m_pc + 5'd1;
            end
         endcase
      end
   endtask

   task automatic mem_load(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = a; tb_wd = d;
      @(negedge clk);
      tb_we = 1'b0;
      m_mem[a] = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) mem_load(5'(i), 8'h00);
      m_pc  = 5'd0;
      m_acc = 8'h00;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Pulses start, then checks every cycle against the model until the HLT lands.
   task automatic run_prog(input string tag);
      cyc_t e;
      model_run();
      chk({tag, "_model_halts"}, m_ok, 1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_mem_rd"}, mem_rd, e.rd);
         chk({tag, "_mem_wr"}, mem_wr, e.wr);
         chk({tag, "_alu_clk"}, alu_clk, e.aclk);
         chk({tag, "_halted_run"}, halted, 0);
         if (e.rd || e.wr) chk({tag, "_mem_addr"}, mem_addr, e.addr);
         if (e.opv) chk({tag, "_alu_op"}, alu_op, e.op);
         @(negedge clk);
      end
      chk({tag, "_halted"}, halted, 1);
      chk({tag, "_accum"}, accum, m_acc);
      chk({tag, "_wdata"}, mem_wdata, m_acc);
      chk({tag, "_pc"}, dut.w_pc, m_pc);
      for (int i = 0; i < 32; i++) chk({tag, "_mem"}, tb_mem[i], m_mem[i]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  snap;
      bit  found;
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_alu_clk", alu_clk, 0);
      chk("rst_halted", halted, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_accum", accum, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_alu_data", alu_data, 0);

      // Load/store
      do_reset();
      mem_load(5'h00, 8'hB0); mem_load(5'h01, 8'hD1); mem_load(5'h02, 8'h00);
      mem_load(5'h10, 8'h5A);
      run_prog("ldst");
      chk("ldst_lit_mem11", tb_mem[17], 8'h5A);
      chk("ldst_lit_accum", accum, 8'h5A);
      chk("ldst_lit_pc", dut.w_pc, 5'd3);

      // Add with dropped carry, single ALU strobe
      do_reset();
      mem_load(5'h00, 8'hB0); mem_load(5'h01, 8'h91); mem_load(5'h02, 8'h00);
      mem_load(5'h10, 8'h70); mem_load(5'h11, 8'h95);
      snap = n_aclk;
      run_prog("add");
      chk("add_lit_accum", accum, 8'h05);
      chk("add_lit_pulses", n_aclk - snap, 1);

      // INC wrap to zero, then DEC back to 0xFF after restarting from HALT
      do_reset();
      mem_load(5'h00, 8'hB0); mem_load(5'h01, 8'h40); mem_load(5'h02, 8'h00);
      mem_load(5'h03, 8'h60); mem_load(5'h04, 8'h00); mem_load(5'h10, 8'hFF);
      run_prog("inc");
      chk("inc_lit_accum", accum, 8'h00);
      chk("inc_lit_zero", zero, 1);
      run_prog("dec");
      chk("dec_lit_accum", accum, 8'hFF);
      chk("dec_lit_pc", dut.w_pc, 5'd5);

      // SKZ taken on zero
      do_reset();
      mem_load(5'h00, 8'hE0); mem_load(5'h01, 8'h00); mem_load(5'h02, 8'h40);
      mem_load(5'h03, 8'h00);
      run_prog("skz1");
      chk("skz1_lit_accum", accum, 8'h01);
      chk("skz1_lit_pc", dut.w_pc, 5'd4);

      // SKZ not taken
      do_reset();
      mem_load(5'h00, 8'hB0); mem_load(5'h01, 8'hE0); mem_load(5'h02, 8'h00);
      mem_load(5'h03, 8'h40); mem_load(5'h04, 8'h00); mem_load(5'h10, 8'h02);
      run_prog("skz0");
      chk("skz0_lit_accum", accum, 8'h02);
      chk("skz0_lit_pc", dut.w_pc, 5'd3);

      // JMP to the top address, PC wraps to 0
      do_reset();
      mem_load(5'h00, 8'h24); mem_load(5'h04, 8'h00); mem_load(5'h05, 8'h3F);
      mem_load(5'h1F, 8'h40);
      run_prog("jmp_a");
      chk("jmp_a_lit_pc", dut.w_pc, 5'd5);
      mem_load(5'h00, 8'h00);
      run_prog("jmp_b");
      chk("jmp_b_lit_accum", accum, 8'h01);
      chk("jmp_b_lit_pc", dut.w_pc, 5'd1);

      // Reset during STORE drops the write strobe at once
      do_reset();
      mem_load(5'h00, 8'hD2); mem_load(5'h12, 8'h33);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (mem_wr) found = 1'b1;
         else @(negedge clk);
      end
      chk("abort_store_seen", found, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_mem_wr", mem_wr, 0);
      chk("abort_mem_rd", mem_rd, 0);
      chk("abort_alu_clk", alu_clk, 0);
      chk("abort_halted", halted, 0);
      chk("abort_mem_addr", mem_addr, 0);
      chk("abort_accum", accum, 0);
      chk("abort_pc", dut.w_pc, 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_mem12", tb_mem[18], 8'h33);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("idle_mem_rd", mem_rd, 0);
         chk("idle_mem_wr", mem_wr, 0);
         chk("idle_alu_clk", alu_clk, 0);
         chk("idle_mem_addr", mem_addr, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/decode/control stage directly upstream of the 8-bit ALU.
- Fetches 8-bit instructions from a synchronous byte memory and decodes them.
- Drives the ALU opcode, operand data, accumulator and the one-cycle alu_clk strobe.
- Consumes the ALU's registered alu_out and its zero flag; owns the PC, instruction register and accumulator.

Parameters:
- ADDR_W, 5, memory address width; PC and operand field width.
- RST_PC, 0, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  leave IDLE/HALT and begin fetching; level-sampled.
- mem_addr  output  ADDR_W  memory address.
- mem_rd  output  1  read request; mem_rdata is valid on the following cycle.
- mem_wr  output  1  write strobe, one cycle.
- mem_wdata  output  8  write data; always equals accum.
- mem_rdata  input  8  read data.
- alu_clk  output  1  registered strobe, high exactly one clk cycle per ALU operation.
- alu_op  output  2  ALU opcode: 00 pass, 01 inc, 10 dec, 11 add.
- alu_data  output  8  operand register sent to the ALU.
- accum  output  8  accumulator sent to the ALU.
- alu_out  input  8  ALU result; valid from the clk cycle after the alu_clk rising edge.
- zero  input  1  ALU flag, equal to (accum == 0).
- halted  output  1  high while in HALT.

Behaviour:
- Instruction format: ir[7:5] opcode, ir[ADDR_W-1:0] operand address; unused bits ignored.
- Opcodes:
  - 000 HLT.
  - 001 JMP: pc <= addr.
  - 010 INC.
  - 011 DEC.
  - 100 ADD: accum += mem[addr].
  - 101 LDA: accum <= mem[addr].
  - 110 STO: mem[addr] <= accum.
  - 111 SKZ: pc += 1 if zero.
- Reset (asynchronous):
  - State and registers: state=IDLE, pc=RST_PC; ir, alu_data, accum = 0; alu_op=00.
  - Outputs: mem_rd, mem_wr, alu_clk, halted = 0; mem_addr=RST_PC.
  - Reset mid-instruction aborts it; any write strobe drops immediately.
- States:
  - IDLE: wait for start=1, then go to FETCH.
  - FETCH: mem_addr=pc, mem_rd=1, then go to INSTR.
  - INSTR: ir<=mem_rdata; pc<=pc+1 (wraps modulo 2^ADDR_W); dispatch on ir[7:5] of mem_rdata.
    - HLT -> HALT.
    - JMP -> JUMP.
    - INC, DEC -> EXEC.
    - ADD, LDA -> OPRD.
    - STO -> STORE.
    - SKZ -> SKIP.
  - OPRD: mem_addr=ir addr, mem_rd=1, then go to OPND.
  - OPND: alu_data<=mem_rdata. LDA: accum<=mem_rdata, then FETCH. ADD: go to EXEC.
  - EXEC: alu_clk=1 for this cycle only; alu_op held stable from entry into EXEC through WB; then WB.
  - WB: accum<=alu_out, then FETCH.
  - JUMP: pc<=ir addr, then FETCH.
  - STORE: mem_addr=ir addr, mem_wr=1, mem_wdata=accum, then FETCH.
  - SKIP: if zero, pc<=pc+1 (wraps), then FETCH.
  - HALT: halted=1; pc holds the address after HLT. start=1 -> FETCH (halted drops with the transition).
- Latencies in clk cycles:
  - ADD: 6.
  - INC/DEC: 4.
  - LDA: 4.
  - JMP, STO, SKZ: 3 each.
  - HLT: 2 to reach HALT.
- alu_op per opcode: INC=01, DEC=10, ADD=11; all others 00.
- Arithmetic is 8-bit modulo with no carry: INC of 0xFF gives 0x00; DEC of 0x00 gives 0xFF.
- mem_rd and mem_wr are never high in the same cycle.
- alu_clk is never high outside EXEC.
- mem_addr holds its last value when no access is in progress.
- start is ignored in all states except IDLE and HALT.
- SKZ with zero=0 is a no-op.
- A JMP to its own address loops forever; this is legal.
- A STO overwriting the next instruction takes effect, because the fetch follows the write.

Decomposition:
- Package cpu_pkg holds:
  - Opcode localparams: OP_HLT through OP_SKZ.
  - ALU opcode constants: ALU_PASS, ALU_INC, ALU_DEC, ALU_ADD.
  - State encoding constants.
- The PC is a natural sub-module, cpu_pc:
  - Inputs: load, load value, increment.
  - Parameterised by ADDR_W and RST_PC.
  - Wrap-around modulo 2^ADDR_W.
- The FSM, IR and accumulator stay in cpu_sequencer.

Test Plan:
- Load/store: mem[0]=LDA 0x10, mem[1]=STO 0x11, mem[2]=HLT, mem[0x10]=0x5A; pulse start -> mem[0x11]=0x5A, accum=0x5A, halted=1, pc=3.
- Add and alu_clk count: LDA 0x10 (0x70), ADD 0x11 (0x95), HLT -> accum=0x05 (carry dropped), exactly one alu_clk pulse, alu_op=11 during EXEC.
- INC/DEC wrap: accum=0xFF, then INC -> accum=0x00 and zero=1; a following DEC -> accum=0xFF.
- Skip on zero: accum=0, then SKZ, HLT, INC, HLT -> first HLT skipped, accum=0x01. Repeat with accum=0x02 -> halts at the first HLT with accum=0x02.
- JMP and PC wrap (ADDR_W=5): JMP 0x1F, mem[0x1F]=INC, mem[0x00]=HLT -> pc wraps 0x1F->0x00, accum incremented once, halts.
- Reset mid-instruction: assert rst_n=0 in the STORE cycle -> mem_wr drops immediately, all outputs at reset values, pc=RST_PC; after release, no activity until start.
